shifter_iter: RTL and testbench

//  Multi-cycle shift/rotate unit for the 16-bit execute stage. Accepts operand, op and 4-bit amount,

---
 rtl/shifter_pkg.sv | 24 ++
 rtl/shifter_step.sv | 45 ++++
 rtl/shifter_iter.sv | 143 ++++++++++++++
 tb/tb_shifter_iter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the iterative shift/rotate unit.
//   op_e    : operation encodings on the 3-bit op field (101-111 are illegal)
//   state_e : controller states
package shifter_pkg;

   typedef enum logic [2:0] {
      OP_ROL = 3'b000,
      OP_ROR = 3'b001,
      OP_SLL = 3'b010,
      OP_SRA = 3'b011,
      OP_SRL = 3'b100
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SHIFT = 2'b01,
      S_DONE  = 2'b10
   } state_e;

   function automatic logic op_is_illegal(input logic [2:0] op);
      return (op > OP_SRL);
   endfunction

endpackage

// File: rtl/shifter_step.sv
// One power-of-two shift/rotate step, purely combinational.
// Ports:
//   i_data [WIDTH]  operand
//   i_op   [3]      operation (illegal encodings rotate left)
//   i_k    [AMT_W]  step exponent; shift distance is 2**i_k (always < WIDTH)
//   o_data [WIDTH]  shifted result
import shifter_pkg::*;

module shifter_step #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0]         i_data,
   input  logic [2:0]               i_op,
   input  logic [$clog2(WIDTH)-1:0] i_k,
   output logic [WIDTH-1:0]         o_data
);

   localparam int AMT_W = $clog2(WIDTH);
   localparam logic [AMT_W:0] W_LEN = (AMT_W+1)'(WIDTH);

   logic [AMT_W-1:0] w_sh;
   logic [AMT_W:0]   w_rsh;
   logic [WIDTH-1:0] w_rol;
   logic [WIDTH-1:0] w_ror;

   // i_k never exceeds AMT_W-1, so the distance is at most WIDTH/2 and
   // WIDTH - distance is never zero or WIDTH for the rotate complements.
   assign w_sh  = AMT_W'(1) << i_k;
   assign w_rsh = W_LEN - {1'b0, w_sh};
   assign w_rol = (i_data << w_sh) | (i_data >> w_rsh);
   assign w_ror = (i_data >> w_sh) | (i_data << w_rsh);

   always_comb begin
      o_data = w_rol;
      case (i_op)
         OP_ROL:  o_data = w_rol;
         OP_ROR:  o_data = w_ror;
         OP_SLL:  o_data = i_data << w_sh;
         OP_SRA:  o_data = $signed(i_data) >>> w_sh;
         OP_SRL:  o_data = i_data >> w_sh;
         default: o_data = w_rol;
      endcase
   end

endmodule

// File: rtl/shifter_iter.sv
// Multi-cycle shift/rotate unit: one power-of-two step per cycle, largest
// remaining step first. Latency from accept to done is 1 + popcount(amt).
// Optional macro SHIFTER_ITER_ERR_EN adds o_err and makes illegal ops finish
// immediately with the operand unchanged; otherwise illegal ops rotate left.
// Ports:
//   clk, rst_n      clock (rising edge), async active-low reset
//   i_start         request, accepted when o_ready=1
//   i_in [WIDTH]    operand
//   i_op [3]        000 ROL, 001 ROR, 010 SLL, 011 SRA, 100 SRL
//   i_amt [AMT_W]   shift amount
//   i_abort         cancel an in-flight shift
//   o_ready         can accept i_start this cycle
//   o_done          one-cycle result-valid pulse
//   o_out [WIDTH]   result, held until the next accepted start completes
//   o_err           (SHIFTER_ITER_ERR_EN only) illegal op, valid with o_done
//
// state   | meaning
// S_IDLE  | waiting for start
// S_SHIFT | applying one step per cycle until rem is zero
// S_DONE  | result valid, done pulse; may accept the next start
import shifter_pkg::*;

module shifter_iter #(
   parameter int WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_start,
   input  logic [WIDTH-1:0]         i_in,
   input  logic [2:0]               i_op,
   input  logic [$clog2(WIDTH)-1:0] i_amt,
   input  logic                     i_abort,
   output logic                     o_ready,
   output logic                     o_done,
`ifdef SHIFTER_ITER_ERR_EN
   output logic                     o_err,
`endif
   output logic [WIDTH-1:0]         o_out
);

   localparam int AMT_W = $clog2(WIDTH);

   state_e           r_state;
   state_e           w_state_nxt;
   logic [WIDTH-1:0] r_acc;
   logic [AMT_W-1:0] r_rem;
   logic [2:0]       r_op;
   logic [WIDTH-1:0] r_out;

   logic [AMT_W-1:0] w_k;
   logic [AMT_W-1:0] w_rem_nxt;
   logic [WIDTH-1:0] w_step;
   logic             w_accept;
   logic             w_step_en;
   logic             w_illegal;

`ifdef SHIFTER_ITER_ERR_EN
   logic r_err;
   assign w_illegal = op_is_illegal(i_op);
   assign o_err     = r_err & (r_state == S_DONE);
`else
   assign w_illegal = 1'b0;
`endif

   // Highest set bit of the remaining amount picks this cycle's step.
   always_comb begin
      w_k = '0;
      for (int i = 0; i < AMT_W; i++) begin
         if (r_rem[i]) w_k = AMT_W'(i);
      end
   end

   assign w_rem_nxt = r_rem & ~(AMT_W'(1) << w_k);

   shifter_step #(.WIDTH(WIDTH)) u_step (
      .i_data (r_acc),
      .i_op   (r_op),
      .i_k    (w_k),
      .o_data (w_step)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_step_en   = 1'b0;
      o_ready     = 1'b0;
      o_done      = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            o_ready = 1'b1;
            o_done  = (r_state == S_DONE);
            // start beats abort here; abort only matters while shifting
            if (i_start) begin
               w_accept    = 1'b1;
               w_state_nxt = (w_illegal || i_amt == '0) ? S_DONE : S_SHIFT;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_SHIFT: begin
            if (i_abort) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_step_en = 1'b1;
               if (w_rem_nxt == '0) w_state_nxt = S_DONE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_rem <= '0;
         r_op  <= '0;
         r_out <= '0;
`ifdef SHIFTER_ITER_ERR_EN
         r_err <= 1'b0;
`endif
      end else if (w_accept) begin
         r_acc <= i_in;
         r_rem <= i_amt;
         r_op  <= i_op;
         if (w_state_nxt == S_DONE) r_out <= i_in;
`ifdef SHIFTER_ITER_ERR_EN
         r_err <= w_illegal;
`endif
      end else if (w_step_en) begin
         r_acc <= w_step;
         r_rem <= w_rem_nxt;
         if (w_rem_nxt == '0) r_out <= w_step;
      end
   end

   assign o_out = r_out;

endmodule

// File: tb/tb_shifter_iter.sv
module tb_shifter_iter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] in_d = '0;
   logic [2:0]  op = '0;
   logic [3:0]  amt = '0;
   logic        ready;
   logic        done;
   logic [15:0] out_d;
`ifdef SHIFTER_ITER_ERR_EN
   logic        err;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   shifter_iter #(.WIDTH(16)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (start),
      .i_in    (in_d),
      .i_op    (op),
      .i_amt   (amt),
      .i_abort (abort),
      .o_ready (ready),
      .o_done  (done),
`ifdef SHIFTER_ITER_ERR_EN
      .o_err   (err),
`endif
      .o_out   (out_d)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] d;
      logic [2:0]  o;
      logic [3:0]  a;
      logic [15:0] e;
      int          lat;
      logic        err;
      string       name;
   } vec_t;

   vec_t tbl[6];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference: repeat single-bit moves amt times, or use plain shifts.
   function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [2:0] o, input int a);
      logic [15:0] r;
      r = d;
      case (o)
         3'd0: for (int i = 0; i < a; i++) r = {r[14:0], r[15]};
         3'd1: for (int i = 0; i < a; i++) r = {r[0], r[15:1]};
         3'd2: r = d << a;
         3'd3: r = $signed(d) >>> a;
         3'd4: r = d >> a;
         default: begin
`ifdef SHIFTER_ITER_ERR_EN
            r = d;
`else
            for (int i = 0; i < a; i++) r = {r[14:0], r[15]};
`endif
         end
      endcase
      return r;
   endfunction

   function automatic int ref_lat(input logic [2:0] o, input logic [3:0] a);
`ifdef SHIFTER_ITER_ERR_EN
      if (o > 3'd4) return 1;
`endif
      return 1 + $countones(a);
   endfunction

   function automatic logic ref_err(input logic [2:0] o);
`ifdef SHIFTER_ITER_ERR_EN
      return (o > 3'd4);
`else
      return 1'b0 & o[0];
`endif
   endfunction

   // Called at a negedge; returns at a negedge with ready=1.
   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (!ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!ready) check({name, "_ready_timeout"}, 32'(ready), 32'd1);
   endtask

   // One complete operation. noise=1 pulses start with other operands while busy.
   task automatic run_op(input logic [15:0] d, input logic [2:0] o, input logic [3:0] a,
                         input logic [15:0] exp_out, input int exp_lat, input logic exp_err,
                         input string name, input bit noise);
      int lat;
      wait_ready(name);
      start = 1'b1; in_d = d; op = o; amt = a;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         start = 1'b0;
         if (noise && lat == 1 && !ready) begin
            start = 1'b1;
            in_d  = ~d;
            op    = 3'($urandom_range(0, 4));
            amt   = ~a;
         end
      end while (!done && lat < 40);
      check({name, "_lat"}, 32'(lat), 32'(exp_lat));
      check({name, "_out"}, 32'(out_d), 32'(exp_out));
`ifdef SHIFTER_ITER_ERR_EN
      check({name, "_err"}, 32'(err), 32'(exp_err));
`else
      if (exp_err) check({name, "_err_unexpected"}, 32'(exp_err), 32'd0);
`endif
      @(negedge clk);
      check({name, "_done_single"}, 32'(done), 32'd0);
   endtask

   initial begin
      int lat;
      int pulses;
      int first;
      logic [15:0] d;
      logic [2:0]  o;
      logic [3:0]  a;

      tbl[0] = '{16'h00F1, 3'd2, 4'd5,  16'h1E20, 3, 1'b0, "sll_f1_5"};
      tbl[1] = '{16'h8400, 3'd3, 4'd15, 16'hFFFF, 5, 1'b0, "sra_8400_15"};
      tbl[2] = '{16'h8400, 3'd4, 4'd15, 16'h0001, 5, 1'b0, "srl_8400_15"};
      tbl[3] = '{16'h1234, 3'd1, 4'd4,  16'h4123, 2, 1'b0, "ror_1234_4"};
      tbl[4] = '{16'h1234, 3'd0, 4'd0,  16'h1234, 1, 1'b0, "rol_1234_0"};
`ifdef SHIFTER_ITER_ERR_EN
      tbl[5] = '{16'hABCD, 3'd6, 4'd4,  16'hABCD, 1, 1'b1, "illegal_op"};
`else
      tbl[5] = '{16'hABCD, 3'd6, 4'd4,  16'hBCDA, 2, 1'b0, "illegal_op"};
`endif

      // Reset state
      #1;
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_done",  32'(done),  32'd0);
      check("rst_out",   32'(out_d), 32'd0);
      #11 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("idle_no_done", 32'(done), 32'd0);
      end

      foreach (tbl[i])
         run_op(tbl[i].d, tbl[i].o, tbl[i].a, tbl[i].e, tbl[i].lat, tbl[i].err, tbl[i].name, 1'b0);

      // Start while busy is ignored.
      run_op(16'h0003, 3'd2, 4'd15, 16'h8000, 5, 1'b0, "busy_start_ignored", 1'b1);

      // Abort after one SHIFT cycle: no done, prior result held.
      run_op(16'h00FF, 3'd2, 4'd3, 16'h07F8, 3, 1'b0, "pre_abort", 1'b0);
      wait_ready("abort");
      start = 1'b1; in_d = 16'h1234; op = 3'd0; amt = 4'd7;
      @(negedge clk);
      start = 1'b0;
      check("abort_busy", 32'(ready), 32'd0);
      @(negedge clk);
      abort = 1'b1;
      check("abort_no_done_a", 32'(done), 32'd0);
      @(negedge clk);
      abort = 1'b0;
      check("abort_ready", 32'(ready), 32'd1);
      check("abort_no_done_b", 32'(done), 32'd0);
      check("abort_out_held", 32'(out_d), 32'h07F8);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      check("abort_no_late_done", 32'(pulses), 32'd0);

      // Back-to-back: second start (with abort) in the DONE cycle.
      wait_ready("b2b");
      start = 1'b1; in_d = 16'hF000; op = 3'd4; amt = 4'd3;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         start = 1'b0;
      end while (!done && lat < 40);
      check("b2b_a_lat", 32'(lat), 32'd3);
      check("b2b_a_out", 32'(out_d), 32'h1E00);
      check("b2b_a_ready", 32'(ready), 32'd1);
      start = 1'b1; abort = 1'b1; in_d = 16'h00FF; op = 3'd1; amt = 4'd8;
      pulses = 0; first = 0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         start = 1'b0; abort = 1'b0;
         if (done) begin
            pulses++;
            if (first == 0) begin
               first = i;
               check("b2b_b_out", 32'(out_d), 32'hFF00);
            end
         end
      end
      check("b2b_b_lat", 32'(first), 32'd2);
      check("b2b_b_pulses", 32'(pulses), 32'd1);

      // Reset in the middle of a shift.
      wait_ready("rst_mid");
      start = 1'b1; in_d = 16'h0001; op = 3'd2; amt = 4'd15;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("rst_mid_busy", 32'(ready), 32'd0);
      #1 rst_n = 1'b0;
      #1;
      check("rst_mid_ready", 32'(ready), 32'd1);
      check("rst_mid_done",  32'(done),  32'd0);
      check("rst_mid_out",   32'(out_d), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      check("rst_mid_no_done", 32'(pulses), 32'd0);

      // Randomised operations against the reference model.
      for (int i = 0; i < 150; i++) begin
         d = 16'($urandom);
         o = 3'($urandom_range(0, 7));
         a = 4'($urandom);
         run_op(d, o, a, ref_shift(d, o, int'(a)), ref_lat(o, a), ref_err(o),
                $sformatf("rand%0d", i), 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
